// File: rtl/glitch_sequencer.sv
// Glitch campaign sequencer.
//
// Arms the edge detector, waits for its trigger, waits a programmable delay and
// then drives a glitch pulse of programmable width. Each delay value is tried
// cfg_repeats times, then the delay sweeps from cfg_delay_start up to
// cfg_delay_end in steps of cfg_delay_step.
//
// Optional feature macro: SEQ_TIMEOUT_EN adds a trigger-wait timeout that ends
// the campaign and sets timed_out_o. Without it, timed_out_o is tied low and
// cfg_timeout_i is unused.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i, abort_i    begin a campaign (IDLE only) / stop it from any state
//   cfg_*_i             campaign configuration, latched on start
//   det_arm_o           arm to the edge detector
//   det_trigger_i       trigger from the edge detector
//   glitch_o            glitch drive
//   busy_o, done_o      campaign in progress / one-cycle end pulse
//   cur_delay_o         delay value in use
//   rep_cnt_o           attempt index within the current delay value
//   timed_out_o         sticky trigger-wait timeout flag
module glitch_sequencer #(
  parameter int unsigned DELAY_W   = 16,
  parameter int unsigned WIDTH_W   = 8,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [DELAY_W-1:0]   cfg_delay_start_i,
  input  logic [DELAY_W-1:0]   cfg_delay_step_i,
  input  logic [DELAY_W-1:0]   cfg_delay_end_i,
  input  logic [WIDTH_W-1:0]   cfg_width_i,
  input  logic [COUNT_W-1:0]   cfg_repeats_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  output logic                 det_arm_o,
  input  logic                 det_trigger_i,
  output logic                 glitch_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DELAY_W-1:0]   cur_delay_o,
  output logic [COUNT_W-1:0]   rep_cnt_o,
  output logic                 timed_out_o
);

  typedef enum logic [2:0] {
    StIdle, StArm, StWaitTrig, StDelay, StPulse, StRelease, StNext, StFinish
  } state_e;

  state_e             state_q;
  logic               det_arm_q, glitch_q, busy_q, done_q;
  logic [DELAY_W-1:0] cur_delay_q, dcnt_q;
  logic [COUNT_W-1:0] rep_cnt_q;
  logic [WIDTH_W-1:0] wcnt_q;

  logic [DELAY_W-1:0] cfg_step_q, cfg_end_q;
  logic [WIDTH_W-1:0] cfg_width_q;
  logic [COUNT_W-1:0] cfg_repeats_q;

  logic [COUNT_W:0]   rep_inc;
  logic [COUNT_W-1:0] reps_eff;
  logic [DELAY_W:0]   delay_sum;
  logic [WIDTH_W-1:0] width_m1;

  assign rep_inc   = {1'b0, rep_cnt_q} + {{COUNT_W{1'b0}}, 1'b1};
  assign reps_eff  = (cfg_repeats_q == '0) ? COUNT_W'(1) : cfg_repeats_q;
  // One bit wider so a sweep near the top of the range cannot wrap.
  assign delay_sum = {1'b0, cur_delay_q} + {1'b0, cfg_step_q};
  // Width counter is loaded with width-1; a width of 0 behaves like 1.
  assign width_m1  = (cfg_width_q == '0) ? '0 : cfg_width_q - WIDTH_W'(1);

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cfg_timeout_q, to_cnt_q;
  logic                 timed_out_q;
  assign timed_out_o = timed_out_q;
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout_i;
  assign timed_out_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      det_arm_q     <= 1'b0;
      glitch_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cur_delay_q   <= '0;
      dcnt_q        <= '0;
      rep_cnt_q     <= '0;
      wcnt_q        <= '0;
      cfg_step_q    <= '0;
      cfg_end_q     <= '0;
      cfg_width_q   <= '0;
      cfg_repeats_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      cfg_timeout_q <= '0;
      to_cnt_q      <= '0;
      timed_out_q   <= 1'b0;
`endif
    end else if (abort_i && state_q != StIdle && state_q != StFinish) begin
      // Abort takes priority over any trigger or pulse-end in the same cycle.
      glitch_q  <= 1'b0;
      det_arm_q <= 1'b0;
      state_q   <= StFinish;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            cfg_step_q    <= cfg_delay_step_i;
            cfg_end_q     <= cfg_delay_end_i;
            cfg_width_q   <= cfg_width_i;
            cfg_repeats_q <= cfg_repeats_i;
`ifdef SEQ_TIMEOUT_EN
            cfg_timeout_q <= cfg_timeout_i;
            timed_out_q   <= 1'b0;
`endif
            cur_delay_q   <= cfg_delay_start_i;
            rep_cnt_q     <= '0;
            busy_q        <= 1'b1;
            state_q       <= StArm;
          end
        end
        StArm: begin
          det_arm_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
          state_q   <= StWaitTrig;
        end
        StWaitTrig: begin
          if (det_trigger_i) begin
            dcnt_q  <= cur_delay_q;
            // Zero delay goes straight to PULSE, which raises glitch one cycle later.
            state_q <= (cur_delay_q == '0) ? StPulse : StDelay;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cfg_timeout_q != '0 && (to_cnt_q + TIMEOUT_W'(1)) == cfg_timeout_q) begin
            timed_out_q <= 1'b1;
            det_arm_q   <= 1'b0;
            state_q     <= StFinish;
          end else begin
            to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
          end
`endif
        end
        StDelay: begin
          if (dcnt_q == '0) begin
            glitch_q <= 1'b1;
            wcnt_q   <= width_m1;
            state_q  <= StPulse;
          end else begin
            dcnt_q <= dcnt_q - DELAY_W'(1);
          end
        end
        StPulse: begin
          if (!glitch_q) begin
            glitch_q <= 1'b1;
            wcnt_q   <= width_m1;
          end else if (wcnt_q == '0) begin
            glitch_q  <= 1'b0;
            det_arm_q <= 1'b0;
            state_q   <= StRelease;
          end else begin
            wcnt_q <= wcnt_q - WIDTH_W'(1);
          end
        end
        StRelease: begin
          state_q <= StNext;
        end
        StNext: begin
          if (rep_inc < {1'b0, reps_eff}) begin
            rep_cnt_q <= rep_inc[COUNT_W-1:0];
            state_q   <= StArm;
          end else begin
            rep_cnt_q <= '0;
            if (cfg_step_q == '0 || delay_sum > {1'b0, cfg_end_q}) begin
              state_q <= StFinish;
            end else begin
              cur_delay_q <= delay_sum[DELAY_W-1:0];
              state_q     <= StArm;
            end
          end
        end
        StFinish: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          det_arm_q <= 1'b0;
          glitch_q  <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign det_arm_o   = det_arm_q;
  assign glitch_o    = glitch_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cur_delay_o = cur_delay_q;
  assign rep_cnt_o   = rep_cnt_q;

endmodule
